// File: rtl/data_mem_if.sv
// Request/response bus between the load/store unit (master) and data_mem_pipe (slave).
interface data_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11
);
    localparam int unsigned NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [NB-1:0]     req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wd;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rd;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wd,
        input  req_ready, rsp_valid, rsp_rd, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wd,
        output req_ready, rsp_valid, rsp_rd, rsp_err
    );
endinterface

// File: rtl/data_mem_pipe.sv
// Byte-enabled data RAM behind a valid/ready port, 1- or 2-cycle read latency.
// Optional macro DATA_MEM_CLEAR_EN: zero the whole array after every reset before accepting requests.
module data_mem_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned RD_LAT      = 1,
    parameter bit          WRITE_FIRST = 1'b0,
    parameter bit          LANE_REV    = 1'b1,
    parameter string       INIT_FILE   = "data.mif"
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((RD_LAT != 1 && RD_LAT != 2) || (DATA_W % 8 != 0)) begin : g_param_err
        $error("data_mem_pipe: RD_LAT must be 1 or 2 and DATA_W a multiple of 8");
    end

    if (INIT_FILE != "") begin : g_init_note
        $info("data_mem_pipe: image %s is preloaded by the RAM macro flow", INIT_FILE);
    end

`ifdef DATA_MEM_CLEAR_EN
    typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_we_c;
`else
    typedef enum logic {RUN = 1'b0} state_t;
    localparam state_t RST_STATE = RUN;
`endif

    state_t state_q, state_d;
    logic   ready_q, ready_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state: the sweep walks every word once, then hands over to RUN.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
`ifdef DATA_MEM_CLEAR_EN
        clr_addr_d = clr_addr_q;
        clr_we_c   = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_c   = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end
            end
            default: ;
        endcase
`endif
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            ready_q <= 1'b0;
`ifdef DATA_MEM_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
`ifdef DATA_MEM_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    assign bus.req_ready = ready_q & ~rst;

    logic              accept_c, in_range_c, wr_c;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] old_c, mask_c, merged_c, rdata_c;

    // Lane merge and read-data selection for the request at the current edge.
    always_comb begin
        accept_c   = bus.req_valid & ready_q & ~rst;
        in_range_c = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
        idx_c      = IDX_W'(bus.req_addr);
        old_c      = mem[idx_c];
        mask_c     = '0;
        for (int i = 0; i < int'(NB); i++) begin
            mask_c[8*i +: 8] = {8{LANE_REV ? bus.req_we[NB-1-i] : bus.req_we[i]}};
        end
        merged_c = (old_c & ~mask_c) | (bus.req_wd & mask_c);
        wr_c     = accept_c & in_range_c & (|bus.req_we);
        if (!in_range_c)      rdata_c = '0;
        else if (WRITE_FIRST) rdata_c = merged_c;
        else                  rdata_c = old_c;
    end

    always_ff @(posedge clk) begin
`ifdef DATA_MEM_CLEAR_EN
        if (clr_we_c && !rst) mem[IDX_W'(clr_addr_q)] <= '0;
        else
`endif
        if (wr_c) mem[idx_c] <= merged_c;
    end

    logic              v1_q, e1_q;
    logic [DATA_W-1:0] d1_q;

    // Stage 1: data/err only load on accept so they hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            e1_q <= 1'b0;
        end else begin
            v1_q <= accept_c;
            if (accept_c) begin
                d1_q <= rdata_c;
                e1_q <= ~in_range_c;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              v2_q, e2_q;
        logic [DATA_W-1:0] d2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q <= 1'b0;
                d2_q <= '0;
                e2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    d2_q <= d1_q;
                    e2_q <= e1_q;
                end
            end
        end

        assign bus.rsp_valid = v2_q;
        assign bus.rsp_rd    = d2_q;
        assign bus.rsp_err   = e2_q;
    end else begin : g_lat1
        assign bus.rsp_valid = v1_q;
        assign bus.rsp_rd    = d1_q;
        assign bus.rsp_err   = e1_q;
    end
endmodule

// File: tb/tb_data_mem_pipe.sv
// Two data_mem_pipe configurations driven in lockstep; per-DUT scoreboards check order, latency and data.
module tb_data_mem_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_if #(.DATA_W(32), .ADDR_W(11)) bus_a ();
    data_mem_if #(.DATA_W(32), .ADDR_W(11)) bus_b ();

    data_mem_pipe #(.DATA_W(32), .DEPTH(1000), .ADDR_W(11), .RD_LAT(1),
                    .WRITE_FIRST(1'b0), .LANE_REV(1'b1), .INIT_FILE(""))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    data_mem_pipe #(.DATA_W(32), .DEPTH(1000), .ADDR_W(11), .RD_LAT(2),
                    .WRITE_FIRST(1'b1), .LANE_REV(1'b0), .INIT_FILE(""))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [31:0] rd;
        bit          chk_rd;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          na = 0;
    int          nb = 0;
    int          sent = 0;
    logic [31:0] cur_ea, cur_eb;
    bit          cur_ca, cur_cb, cur_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard A: pop on response, flush on reset, push on handshake.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (bus_a.rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected 0");
            end else begin
                e = qa.pop_front();
                na++;
                check("a_latency", 32'(cyc - e.cyc), 32'd1);
                if (e.chk_rd) check("a_rsp_rd", bus_a.rsp_rd, e.rd);
                check("a_rsp_err", 32'(bus_a.rsp_err), 32'(e.err));
            end
        end
        if (rst) qa.delete();
        else if (bus_a.req_valid && bus_a.req_ready) qa.push_back('{cur_ea, cur_ca, cur_err, cyc});
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (bus_b.rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected 0");
            end else begin
                e = qb.pop_front();
                nb++;
                check("b_latency", 32'(cyc - e.cyc), 32'd2);
                if (e.chk_rd) check("b_rsp_rd", bus_b.rsp_rd, e.rd);
                check("b_rsp_err", 32'(bus_b.rsp_err), 32'(e.err));
            end
        end
        if (rst) qb.delete();
        else if (bus_b.req_valid && bus_b.req_ready) qb.push_back('{cur_eb, cur_cb, cur_err, cyc});
    end

    task automatic drive(input logic [3:0] we, input logic [10:0] addr, input logic [31:0] wd,
                         input logic [31:0] ea, input bit ca,
                         input logic [31:0] eb, input bit cb, input bit err);
        bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wd = wd;
        bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wd = wd;
        cur_ea = ea; cur_ca = ca; cur_eb = eb; cur_cb = cb; cur_err = err;
        sent++;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus_a.req_valid = 1'b0; bus_a.req_we = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_a_pending"}, 32'(qa.size()), 32'd0);
        check({tag, "_b_pending"}, 32'(qb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] s_addr [4];
        logic [31:0] s_ea   [4];
        logic [31:0] s_eb   [4];
        int          na0, nb0;

        s_addr = '{11'd5, 11'd7, 11'd476, 11'd999};
        s_ea   = '{32'h112233AA, 32'h00000002, 32'h00476476, 32'h12340999};
        s_eb   = '{32'hAA223344, 32'h00000002, 32'h00476476, 32'h00005678};

        idle();
        bus_a.req_addr = '0; bus_a.req_wd = '0;
        bus_b.req_addr = '0; bus_b.req_wd = '0;
        cur_ea = '0; cur_eb = '0; cur_ca = 1'b0; cur_cb = 1'b0; cur_err = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_b_valid", 32'(bus_b.rsp_valid), 32'd0);
        check("rst_a_rd",    bus_a.rsp_rd,         32'd0);
        check("rst_b_rd",    bus_b.rsp_rd,         32'd0);
        check("rst_a_err",   32'(bus_a.rsp_err),   32'd0);
        check("rst_b_err",   32'(bus_b.rsp_err),   32'd0);
        check("rst_a_ready", 32'(bus_a.req_ready), 32'd0);
        check("rst_b_ready", 32'(bus_b.req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("run_a_ready", 32'(bus_a.req_ready), 32'd1);
        check("run_b_ready", 32'(bus_b.req_ready), 32'd1);

        // we, addr, wd, exp A (pre-write, reversed lanes), exp B (merged, straight lanes), err
        drive(4'hF, 11'd5,    32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF, 1, 0);
        drive(4'h0, 11'd5,    32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
        drive(4'hF, 11'd5,    32'h11223344, 32'hDEADBEEF, 1, 32'h11223344, 1, 0);
        drive(4'h8, 11'd5,    32'hAA0000AA, 32'h11223344, 1, 32'hAA223344, 1, 0);
        drive(4'h0, 11'd5,    32'h0,        32'h112233AA, 1, 32'hAA223344, 1, 0);
        drive(4'hF, 11'd7,    32'h00000001, 32'h0,        0, 32'h00000001, 1, 0);
        drive(4'h0, 11'd7,    32'h0,        32'h00000001, 1, 32'h00000001, 1, 0);
        drive(4'hF, 11'd7,    32'h00000002, 32'h00000001, 1, 32'h00000002, 1, 0);
        drive(4'hF, 11'd476,  32'h00476476, 32'h0,        0, 32'h00476476, 1, 0);
        drive(4'hF, 11'd1500, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        1, 1);
        drive(4'h0, 11'd1500, 32'h0,        32'h0,        1, 32'h0,        1, 1);
        drive(4'h0, 11'd476,  32'h0,        32'h00476476, 1, 32'h00476476, 1, 0);
        drive(4'hF, 11'd999,  32'h00000999, 32'h0,        0, 32'h00000999, 1, 0);
        drive(4'h3, 11'd999,  32'h12345678, 32'h00000999, 1, 32'h00005678, 1, 0);
        drive(4'h0, 11'd999,  32'h0,        32'h12340999, 1, 32'h00005678, 1, 0);
        drive(4'h0, 11'd1000, 32'h0,        32'h0,        1, 32'h0,        1, 1);
        drive(4'h0, 11'd7,    32'h0,        32'h00000002, 1, 32'h00000002, 1, 0);
        idle();
        drain("directed");
        check("directed_a_count", 32'(na), 32'(sent));
        check("directed_b_count", 32'(nb), 32'(sent));

        na0 = na; nb0 = nb;
        for (int i = 0; i < 16; i++)
            drive(4'h0, s_addr[i%4], 32'h0, s_ea[i%4], 1, s_eb[i%4], 1, 0);
        idle();
        drain("stream");
        check("stream_a_count", 32'(na - na0), 32'd16);
        check("stream_b_count", 32'(nb - nb0), 32'd16);

        // Reset lands with valid still high; in-flight responses must vanish.
        na0 = na; nb0 = nb;
        for (int i = 0; i < 6; i++)
            drive(4'h0, s_addr[i%4], 32'h0, s_ea[i%4], 1, s_eb[i%4], 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_a_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("midrst_b_valid", 32'(bus_b.rsp_valid), 32'd0);
        check("midrst_a_rd",    bus_a.rsp_rd,         32'd0);
        check("midrst_b_rd",    bus_b.rsp_rd,         32'd0);
        idle();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_a_count", 32'(na - na0), 32'd6);
        check("midrst_b_count", 32'(nb - nb0), 32'd5);
        check("midrst_a_ready", 32'(bus_a.req_ready), 32'd1);

        drive(4'h0, 11'd5,    32'h0, 32'h112233AA, 1, 32'hAA223344, 1, 0);
        drive(4'hF, 11'd1500, 32'h1, 32'h0,        1, 32'h0,        1, 1);
        drive(4'h0, 11'd476,  32'h0, 32'h00476476, 1, 32'h00476476, 1, 0);
        idle();
        drain("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
